// File: rtl/pll_lock_rst_gen.sv
// Reset sequencer behind the PLL: debounces lock, releases sys_rst_n, counts losses.
// Optional PLL reset retry on lock timeout is enabled by defining PLL_RST_RETRY_EN.
module pll_lock_rst_gen #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES      = 32,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  output logic             sys_rst_n,
  output logic             rst_done,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic             lock_timeout,
  output logic             pll_rst,
  output logic [2:0]       state
);

  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int PW = $clog2(PLL_RST_CYCLES + 1);

  localparam logic [TW-1:0] TMO_MAX  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PRST_MAX = PW'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_STABLE  = 3'd1,
    S_HOLD    = 3'd2,
    S_RUN     = 3'd3,
    S_PLL_RST = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]    prst_cnt_q, prst_cnt_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             rst_done_q, rst_done_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
  logic             lock_timeout_q, lock_timeout_d;
  logic             pll_rst_q, pll_rst_d;
  logic             lock_s;
  logic             tmo_hit;

  always_comb begin
    state_d        = state_q;
    sync_d         = {sync_q[0], pll_lock};
    tmo_cnt_d      = tmo_cnt_q;
    stab_cnt_d     = stab_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    prst_cnt_d     = prst_cnt_q;
    sys_rst_n_d    = sys_rst_n_q;
    rst_done_d     = rst_done_q;
    lock_lost_d    = 1'b0;
    lost_cnt_d     = lost_cnt_q;
    lock_timeout_d = lock_timeout_q;
    pll_rst_d      = pll_rst_q;
    lock_s         = sync_q[1];
    tmo_hit        = (tmo_cnt_q == TMO_MAX);

    if ((state_q == S_WAIT || state_q == S_STABLE) && !tmo_hit)
      tmo_cnt_d = tmo_cnt_q + TW'(1);

    unique case (state_q)
      S_WAIT: begin
        if (tmo_hit) lock_timeout_d = 1'b1;
        if (lock_s) begin
          state_d    = S_STABLE;
          stab_cnt_d = '0;
        end
`ifdef PLL_RST_RETRY_EN
        if (tmo_hit && !lock_s) begin
          state_d    = S_PLL_RST;
          prst_cnt_d = '0;
          pll_rst_d  = 1'b1;
          tmo_cnt_d  = '0;
        end
`endif
      end
      S_STABLE: begin
        if (tmo_hit) lock_timeout_d = 1'b1;
        if (!lock_s) begin
          state_d = S_WAIT;
        end else if (stab_cnt_q == STAB_MAX) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1);
        end
`ifdef PLL_RST_RETRY_EN
        if (tmo_hit) begin
          state_d    = S_PLL_RST;
          prst_cnt_d = '0;
          pll_rst_d  = 1'b1;
          tmo_cnt_d  = '0;
        end
`endif
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_WAIT;
        end else if (hold_cnt_q == HOLD_MAX) begin
          state_d     = S_RUN;
          sys_rst_n_d = 1'b1;
          rst_done_d  = 1'b1;
          tmo_cnt_d   = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d     = S_WAIT;
          sys_rst_n_d = 1'b0;
          rst_done_d  = 1'b0;
          lock_lost_d = 1'b1;
          if (lost_cnt_q != '1)
            lost_cnt_d = lost_cnt_q + CNT_W'(1);
        end
      end
      S_PLL_RST: begin
        // only reachable with the retry build
        if (prst_cnt_q == PRST_MAX) begin
          state_d   = S_WAIT;
          pll_rst_d = 1'b0;
        end else begin
          prst_cnt_d = prst_cnt_q + PW'(1);
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_WAIT;
      sync_q         <= '0;
      tmo_cnt_q      <= '0;
      stab_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      prst_cnt_q     <= '0;
      sys_rst_n_q    <= 1'b0;
      rst_done_q     <= 1'b0;
      lock_lost_q    <= 1'b0;
      lost_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
      pll_rst_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      tmo_cnt_q      <= tmo_cnt_d;
      stab_cnt_q     <= stab_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      prst_cnt_q     <= prst_cnt_d;
      sys_rst_n_q    <= sys_rst_n_d;
      rst_done_q     <= rst_done_d;
      lock_lost_q    <= lock_lost_d;
      lost_cnt_q     <= lost_cnt_d;
      lock_timeout_q <= lock_timeout_d;
      pll_rst_q      <= pll_rst_d;
    end
  end

  assign sys_rst_n     = sys_rst_n_q;
  assign rst_done      = rst_done_q;
  assign lock_lost     = lock_lost_q;
  assign lock_lost_cnt = lost_cnt_q;
  assign lock_timeout  = lock_timeout_q;
  assign pll_rst       = pll_rst_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Directed bench for pll_lock_rst_gen with small timing parameters.
// Covers release latency, glitch, loss, saturation, timeout and async reset.
module tb_pll_lock_rst_gen;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       sys_rst_n;
  logic       rst_done;
  logic       lock_lost;
  logic [7:0] lock_lost_cnt;
  logic       lock_timeout;
  logic       pll_rst;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  pll_lock_rst_gen #(
    .LOCK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES(64),
    .PLL_RST_CYCLES     (8),
    .CNT_W              (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .sys_rst_n    (sys_rst_n),
    .rst_done     (rst_done),
    .lock_lost    (lock_lost),
    .lock_lost_cnt(lock_lost_cnt),
    .lock_timeout (lock_timeout),
    .pll_rst      (pll_rst),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // leaves time at 1 after an edge; the following edge is edge 1
  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pll_lock = 1'b0;
    rst_n = 1'b0;
    tick(2);
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL rst_state got=%0d exp=0", state);
    end
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++; $display("FAIL rst_sys got=%b exp=0", sys_rst_n);
    end
    total++;
    if ({rst_done, lock_lost, lock_timeout, pll_rst} !== 4'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=0000",
               {rst_done, lock_lost, lock_timeout, pll_rst});
    end
    total++;
    if (lock_lost_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d exp=0", lock_lost_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    pll_lock = 1'b0;
    do_reset();
    tick(9);
    pll_lock = 1'b1;
    tick(14);
    total++;
    if (sys_rst_n !== 1'b0 || state !== 3'd2) begin
      bad++;
      $display("FAIL clean_e23 sys=%b st=%0d exp sys=0 st=2", sys_rst_n, state);
    end
    tick(1);
    total++;
    if (sys_rst_n !== 1'b1 || rst_done !== 1'b1) begin
      bad++;
      $display("FAIL clean_e24 sys=%b done=%b exp 1 1", sys_rst_n, rst_done);
    end
    total++;
    if (state !== 3'd3) begin
      bad++; $display("FAIL clean_state got=%0d exp=3", state);
    end
    total++;
    if (lock_lost_cnt !== 8'd0 || lock_timeout !== 1'b0) begin
      bad++;
      $display("FAIL clean_misc cnt=%0d tmo=%b exp 0 0", lock_lost_cnt, lock_timeout);
    end
  endtask

  task automatic test_glitch();
    pll_lock = 1'b0;
    do_reset();
    tick(2);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      total++;
      if (sys_rst_n !== 1'b0 || lock_lost !== 1'b0) begin
        bad++;
        $display("FAIL glitch_c%0d sys=%b lost=%b exp 0 0", i, sys_rst_n, lock_lost);
      end
    end
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL glitch_state got=%0d exp=0", state);
    end
    pll_lock = 1'b1;
    tick(14);
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++; $display("FAIL glitch_pre got=%b exp=0", sys_rst_n);
    end
    tick(1);
    total++;
    if (sys_rst_n !== 1'b1 || lock_lost_cnt !== 8'd0 || lock_timeout !== 1'b0) begin
      bad++;
      $display("FAIL glitch_rel sys=%b cnt=%0d tmo=%b exp 1 0 0",
               sys_rst_n, lock_lost_cnt, lock_timeout);
    end
  endtask

  // starts in RUN with lock_lost_cnt=0
  task automatic test_lock_loss();
    pll_lock = 1'b0;
    tick(2);
    total++;
    if (sys_rst_n !== 1'b1 || lock_lost !== 1'b0) begin
      bad++;
      $display("FAIL loss_f1 sys=%b lost=%b exp 1 0", sys_rst_n, lock_lost);
    end
    tick(1);
    total++;
    if (sys_rst_n !== 1'b0 || rst_done !== 1'b0 || lock_lost !== 1'b1) begin
      bad++;
      $display("FAIL loss_f2 sys=%b done=%b lost=%b exp 0 0 1",
               sys_rst_n, rst_done, lock_lost);
    end
    total++;
    if (lock_lost_cnt !== 8'd1 || state !== 3'd0) begin
      bad++;
      $display("FAIL loss_cnt cnt=%0d st=%0d exp 1 0", lock_lost_cnt, state);
    end
    tick(1);
    total++;
    if (lock_lost !== 1'b0) begin
      bad++; $display("FAIL loss_pulse got=%b exp=0", lock_lost);
    end
    pll_lock = 1'b1;
    tick(14);
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++; $display("FAIL loss_relock_pre got=%b exp=0", sys_rst_n);
    end
    tick(1);
    total++;
    if (sys_rst_n !== 1'b1 || lock_lost_cnt !== 8'd1) begin
      bad++;
      $display("FAIL loss_relock sys=%b cnt=%0d exp 1 1", sys_rst_n, lock_lost_cnt);
    end
  endtask

  // starts in RUN with lock_lost_cnt=1
  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      pll_lock = 1'b0;
      tick(3);
      pll_lock = 1'b1;
      tick(15);
      if (i == 252) begin
        total++;
        if (lock_lost_cnt !== 8'd254) begin
          bad++; $display("FAIL sat_254 got=%0d exp=254", lock_lost_cnt);
        end
      end
    end
    total++;
    if (lock_lost_cnt !== 8'd255 || sys_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL sat_final cnt=%0d sys=%b exp 255 1", lock_lost_cnt, sys_rst_n);
    end
    pll_lock = 1'b0;
    tick(3);
    total++;
    if (lock_lost !== 1'b1 || lock_lost_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_hold lost=%b cnt=%0d exp 1 255", lock_lost, lock_lost_cnt);
    end
    pll_lock = 1'b1;
    tick(15);
  endtask

  task automatic test_timeout();
    pll_lock = 1'b0;
    do_reset();
    for (int i = 1; i < 64; i++) begin
      tick(1);
      total++;
      if (lock_timeout !== 1'b0 || pll_rst !== 1'b0) begin
        bad++;
        $display("FAIL tmo_early_e%0d tmo=%b prst=%b exp 0 0", i, lock_timeout, pll_rst);
      end
    end
    tick(1);
    total++;
    if (lock_timeout !== 1'b1) begin
      bad++; $display("FAIL tmo_e64 got=%b exp=1", lock_timeout);
    end
`ifdef PLL_RST_RETRY_EN
    total++;
    if (pll_rst !== 1'b1 || state !== 3'd4) begin
      bad++; $display("FAIL prst_on prst=%b st=%0d exp 1 4", pll_rst, state);
    end
    tick(7);
    total++;
    if (pll_rst !== 1'b1) begin
      bad++; $display("FAIL prst_e71 got=%b exp=1", pll_rst);
    end
    tick(1);
    total++;
    if (pll_rst !== 1'b0 || state !== 3'd0) begin
      bad++; $display("FAIL prst_off prst=%b st=%0d exp 0 0", pll_rst, state);
    end
    tick(63);
    total++;
    if (pll_rst !== 1'b0) begin
      bad++; $display("FAIL prst_e135 got=%b exp=0", pll_rst);
    end
    tick(1);
    total++;
    if (pll_rst !== 1'b1 || lock_timeout !== 1'b1) begin
      bad++; $display("FAIL prst_again prst=%b tmo=%b exp 1 1", pll_rst, lock_timeout);
    end
`else
    for (int i = 0; i < 30; i++) begin
      tick(1);
      total++;
      if (pll_rst !== 1'b0 || state !== 3'd0) begin
        bad++; $display("FAIL tmo_stay_c%0d prst=%b st=%0d exp 0 0", i, pll_rst, state);
      end
    end
`endif
    pll_lock = 1'b1;
    tick(40);
    total++;
    if (rst_done !== 1'b1 || lock_timeout !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky done=%b tmo=%b exp 1 1", rst_done, lock_timeout);
    end
  endtask

  // starts in RUN with lock_timeout=1
  task automatic test_async_reset();
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(15);
    total++;
    if (lock_lost_cnt !== 8'd1 || state !== 3'd3) begin
      bad++; $display("FAIL ar_setup cnt=%0d st=%0d exp 1 3", lock_lost_cnt, state);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (sys_rst_n !== 1'b0 || rst_done !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL ar_run sys=%b done=%b st=%0d exp 0 0 0", sys_rst_n, rst_done, state);
    end
    total++;
    if (lock_lost_cnt !== 8'd0 || lock_timeout !== 1'b0) begin
      bad++;
      $display("FAIL ar_run_cnt cnt=%0d tmo=%b exp 0 0", lock_lost_cnt, lock_timeout);
    end
    tick(2);
    rst_n = 1'b1;
    tick(12);
    total++;
    if (state !== 3'd2) begin
      bad++; $display("FAIL ar_hold_setup got=%0d exp=2", state);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || sys_rst_n !== 1'b0) begin
      bad++; $display("FAIL ar_hold st=%0d sys=%b exp 0 0", state, sys_rst_n);
    end
    tick(2);
    rst_n = 1'b1;
    tick(14);
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++; $display("FAIL ar_restart_pre got=%b exp=0", sys_rst_n);
    end
    tick(1);
    total++;
    if (sys_rst_n !== 1'b1 || rst_done !== 1'b1) begin
      bad++;
      $display("FAIL ar_restart sys=%b done=%b exp 1 1", sys_rst_n, rst_done);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    test_reset();
    test_clean_lock();
    test_lock_loss();
    test_saturation();
    test_glitch();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
